// File: rtl/vga_pkg.sv
// Shared constants and FSM state type for the VGA tile-memory arbiter.
// The tile map is 40 x 30 tiles of 16x16 pixels, one 4-bit digit code per tile.
package vga_pkg;

  localparam int TILE_COLS = 40;
  localparam int TILE_ROWS = 30;
  localparam int DEPTH     = TILE_COLS * TILE_ROWS;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 4;
  localparam logic [DATA_W-1:0] BLANK = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/vga_clear_seq.sv
// Clear sequencer: walks every tile address once, emitting a write strobe
// in each cycle that the display does not hold the memory port.
module vga_clear_seq
  import vga_pkg::*;
#(
  parameter int DEPTH  = vga_pkg::DEPTH,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              we
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1'b1);

  clr_state_e        state_r;
  clr_state_e        state_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_s;

  // State and address counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next state, counter advance and write strobe
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    busy    = 1'b0;
    we      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_CLEAR;
          cnt_s   = ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (pause) begin
          we = 1'b0;
        end else if (cnt_r == LAST) begin
          we      = 1'b1;
          state_s = ST_IDLE;
          cnt_s   = ZERO;
        end else begin
          we    = 1'b1;
          cnt_s = cnt_r + ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = ZERO;
      end
    endcase
  end

  assign addr = cnt_r;

endmodule

// File: rtl/vga_tile_mem_arbiter.sv
// Single-port tile memory arbiter: display reads beat the clear sequencer,
// which beats host accesses; read data is steered back by a 1-bit owner tag.
module vga_tile_mem_arbiter
  import vga_pkg::*;
#(
  parameter int                DEPTH      = vga_pkg::DEPTH,
  parameter int                ADDR_W     = vga_pkg::ADDR_W,
  parameter int                DATA_W     = vga_pkg::DATA_W,
  parameter logic [DATA_W-1:0] BLANK      = vga_pkg::BLANK,
  parameter int                STARVE_LIM = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              err_starve,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              SW         = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [SW-1:0]   STARVE_ONE = SW'(1'b1);
  localparam logic [DATA_W-1:0] DZERO    = {DATA_W{1'b0}};

  logic              clr_busy_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              host_ready_s;
  logic              host_acc_s;
  logic              rd_issue_s;
  logic              rd_host_s;
  logic              rd_pend_r;
  logic              owner_r;
  logic [SW-1:0]     starve_cnt_r;
  logic [SW-1:0]     starve_cnt_s;
  logic              starve_hit_s;
  logic              err_starve_r;

  vga_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk   (clk),
    .reset (reset),
    .start (clr_start),
    .pause (disp_req),
    .busy  (clr_busy_s),
    .addr  (clr_addr_s),
    .we    (clr_we_s)
  );

  // The sequencer is busy exactly when the FSM is in CLEAR.
  assign host_ready_s = !disp_req && !clr_busy_s;
  assign host_acc_s   = host_valid && host_ready_s;
  assign rd_issue_s   = disp_req || (host_acc_s && !host_we);
  assign rd_host_s    = host_acc_s && !host_we;

  // Memory port grant: display > clear > host
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = DZERO;
    if (reset) begin
      mem_en = 1'b0;
    end else if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (clr_we_s) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = clr_addr_s;
      mem_wdata = BLANK;
    end else if (host_acc_s) begin
      mem_en   = 1'b1;
      mem_we   = host_we;
      mem_addr = host_addr;
      if (host_we) begin
        mem_wdata = host_wdata;
      end else begin
        mem_wdata = DZERO;
      end
    end else begin
      mem_en = 1'b0;
    end
  end

  // Host starvation counter: held while clearing, saturating at the limit
  always_comb begin
    starve_cnt_s = starve_cnt_r;
    if (clr_busy_s) begin
      starve_cnt_s = starve_cnt_r;
    end else if (host_valid && !host_ready_s) begin
      if (starve_cnt_r == STARVE_MAX) begin
        starve_cnt_s = starve_cnt_r;
      end else begin
        starve_cnt_s = starve_cnt_r + STARVE_ONE;
      end
    end else begin
      starve_cnt_s = {SW{1'b0}};
    end
  end

  assign starve_hit_s = (starve_cnt_s == STARVE_MAX);

  // Read-return tag and sticky starvation flag
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_r    <= 1'b0;
      owner_r      <= 1'b0;
      starve_cnt_r <= {SW{1'b0}};
      err_starve_r <= 1'b0;
    end else begin
      rd_pend_r    <= rd_issue_s;
      owner_r      <= rd_host_s;
      starve_cnt_r <= starve_cnt_s;
      err_starve_r <= err_starve_r || starve_hit_s;
    end
  end

  // Route returning read data to its owner; the idle side reads zero
  always_comb begin
    disp_rdata = DZERO;
    host_rdata = DZERO;
    if (rd_pend_r && owner_r) begin
      host_rdata = mem_rdata;
    end else if (rd_pend_r) begin
      disp_rdata = mem_rdata;
    end else begin
      disp_rdata = DZERO;
    end
  end

  assign disp_rvalid = rd_pend_r && !owner_r;
  assign host_rvalid = rd_pend_r && owner_r;
  assign host_ready  = host_ready_s;
  assign clr_busy    = clr_busy_s;
  assign err_starve  = err_starve_r;

endmodule

// File: tb/tb_vga_tile_mem_arbiter.sv
// Scoreboard bench for vga_tile_mem_arbiter with a behavioural 1-cycle
// latency memory attached to the mem_* port.
module tb_vga_tile_mem_arbiter;

  localparam int         DEPTH  = 1200;
  localparam int         ADDR_W = 11;
  localparam int         DATA_W = 4;
  localparam logic [3:0] BLANK  = 4'hF;

  logic              clk = 1'b0;
  logic              reset;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              host_valid;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ready;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              clr_start;
  logic              clr_busy;
  logic              err_starve;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = 4'h0;

  typedef struct {
    logic [3:0] data;
    int         cyc;
  } exp_t;

  exp_t       disp_q[$];
  exp_t       host_q[$];
  exp_t       m_e;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [3:0] tmem [DEPTH];
  logic       seen [DEPTH];

  vga_tile_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .host_valid  (host_valid),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ready  (host_ready),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .err_starve  (err_starve),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port memory with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tmem[mem_addr];
    end
  end

  // Scoreboard: pop expected read data whenever a valid returns
  always @(negedge clk) begin
    if (disp_rvalid && host_rvalid) begin
      total++; bad++;
      $display("FAIL both_rvalid: disp_rvalid=1 host_rvalid=1, required at most one");
    end
    if (disp_rvalid) begin
      total++;
      if (disp_q.size() == 0) begin
        bad++;
        $display("FAIL disp_unexpected: disp_rvalid=1 at cycle %0d with nothing pending", cyc);
      end else begin
        m_e = disp_q.pop_front();
        if (disp_rdata !== m_e.data || cyc !== m_e.cyc) begin
          bad++;
          $display("FAIL disp_read: got data %0h at cycle %0d, required %0h at cycle %0d",
                   disp_rdata, cyc, m_e.data, m_e.cyc);
        end
      end
    end
    if (host_rvalid) begin
      total++;
      if (host_q.size() == 0) begin
        bad++;
        $display("FAIL host_unexpected: host_rvalid=1 at cycle %0d with nothing pending", cyc);
      end else begin
        m_e = host_q.pop_front();
        if (host_rdata !== m_e.data || cyc !== m_e.cyc) begin
          bad++;
          $display("FAIL host_read: got data %0h at cycle %0d, required %0h at cycle %0d",
                   host_rdata, cyc, m_e.data, m_e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 1'b0; disp_addr = 11'd0;
    host_valid = 1'b0; host_we = 1'b0; host_addr = 11'd0; host_wdata = 4'd0;
    clr_start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 8 && (disp_q.size() != 0 || host_q.size() != 0); i++) tick();
    total++;
    if (disp_q.size() != 0 || host_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: pending disp=%0d host=%0d, required 0", name, disp_q.size(), host_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    @(negedge clk);
    total++;
    if ({clr_busy, err_starve} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: busy,err=%b required 00", {clr_busy, err_starve});
    end
    total++;
    if ({disp_rvalid, host_rvalid, disp_rdata, host_rdata} !== 10'd0) begin
      bad++; $display("FAIL reset_read: got %h required 0", {disp_rvalid, host_rvalid, disp_rdata, host_rdata});
    end
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 17'd0) begin
      bad++; $display("FAIL reset_mem: got %h required 0", {mem_en, mem_we, mem_addr, mem_wdata});
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (host_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: host_ready=%b required 1", host_ready);
    end
    tick();
  endtask

  task automatic test_host_rw();
    host_valid = 1'b1; host_we = 1'b1; host_addr = 11'd5; host_wdata = 4'd3;
    @(negedge clk);
    total++;
    if ({host_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 1'b1, 11'd5, 4'd3}) begin
      bad++; $display("FAIL host_write: ready,en,we,addr,wdata=%h required %h",
                      {host_ready, mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 1'b1, 11'd5, 4'd3});
    end
    tick();
    host_we = 1'b0; host_wdata = 4'd0;
    host_q.push_back('{4'd3, cyc + 1});
    @(negedge clk);
    total++;
    if ({host_ready, mem_en, mem_we} !== 3'b110) begin
      bad++; $display("FAIL host_read_issue: ready,en,we=%b required 110", {host_ready, mem_en, mem_we});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({mem_en, mem_we, mem_addr, mem_wdata} !== 17'd0) begin
      bad++; $display("FAIL idle_mem: got %h required 0", {mem_en, mem_we, mem_addr, mem_wdata});
    end
    wait_drain("host_rw");
  endtask

  task automatic test_disp_priority();
    disp_req = 1'b1; disp_addr = 11'd5;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 11'd5;
    disp_q.push_back('{4'd3, cyc + 1});
    @(negedge clk);
    total++;
    if ({host_ready, mem_en, mem_we, mem_addr} !== {1'b0, 1'b1, 1'b0, 11'd5}) begin
      bad++; $display("FAIL disp_prio: ready,en,we,addr=%h required %h",
                      {host_ready, mem_en, mem_we, mem_addr}, {1'b0, 1'b1, 1'b0, 11'd5});
    end
    tick();
    disp_req = 1'b0;
    host_q.push_back('{4'd3, cyc + 1});
    @(negedge clk);
    total++;
    if (host_ready !== 1'b1) begin
      bad++; $display("FAIL host_after_disp: host_ready=%b required 1", host_ready);
    end
    tick();
    idle_inputs();
    wait_drain("disp_prio");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      host_valid = 1'b1; host_we = 1'b1;
      host_addr = 11'(100 + i * 37); host_wdata = 4'(i * 5 + 1);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      disp_req = 1'b1; disp_addr = 11'(100 + i * 37);
      disp_q.push_back('{4'(i * 5 + 1), cyc + 1});
      tick();
    end
    disp_req = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      host_valid = 1'b1; host_we = 1'b0; host_addr = 11'(100 + i * 37);
      host_q.push_back('{4'(i * 5 + 1), cyc + 1});
      tick();
    end
    idle_inputs();
    wait_drain("back_to_back");
  endtask

  task automatic test_clear();
    int busy_cyc = 0;
    int disp_cyc = 0;
    int wr = 0;
    int badwr = 0;
    int rdy_bad = 0;
    int covered = 0;
    for (int i = 0; i < DEPTH; i++) seen[i] = 1'b0;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 11'd1; host_wdata = 4'd2;
    clr_start = 1'b1;
    @(negedge clk);
    total++;
    if ({host_ready, mem_we, mem_addr} !== {1'b1, 1'b1, 11'd1}) begin
      bad++; $display("FAIL clr_start_host: ready,we,addr=%h required %h",
                      {host_ready, mem_we, mem_addr}, {1'b1, 1'b1, 11'd1});
    end
    tick();
    idle_inputs();
    for (int n = 0; n < 2000; n++) begin
      if (!clr_busy) break;
      busy_cyc++;
      disp_req  = (n % 16 == 15);
      disp_addr = 11'd0;
      clr_start = (n == 500);
      if (disp_req) begin
        disp_cyc++;
        disp_q.push_back('{BLANK, cyc + 1});
      end
      @(negedge clk);
      if (host_ready) rdy_bad++;
      if (mem_en && mem_we) begin
        wr++;
        if (mem_wdata !== BLANK || disp_req) badwr++;
        else seen[mem_addr] = 1'b1;
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) if (seen[i]) covered++;
    total++;
    if (clr_busy !== 1'b0) begin
      bad++; $display("FAIL clr_timeout: clr_busy=%b after budget, required 0", clr_busy);
    end
    total++;
    if (wr !== 1200 || badwr !== 0 || covered !== 1200) begin
      bad++; $display("FAIL clr_writes: writes=%0d bad=%0d covered=%0d, required 1200/0/1200", wr, badwr, covered);
    end
    total++;
    if (busy_cyc !== 1200 + disp_cyc || disp_cyc !== 79) begin
      bad++; $display("FAIL clr_busy_len: busy=%0d disp=%0d, required %0d and 79", busy_cyc, disp_cyc, 1200 + disp_cyc);
    end
    total++;
    if (rdy_bad !== 0) begin
      bad++; $display("FAIL clr_ready: host_ready high %0d cycles, required 0", rdy_bad);
    end
    disp_req = 1'b1; disp_addr = 11'd137;
    disp_q.push_back('{BLANK, cyc + 1});
    tick();
    disp_req = 1'b0;
    host_valid = 1'b1; host_we = 1'b0; host_addr = 11'd1;
    host_q.push_back('{BLANK, cyc + 1});
    tick();
    idle_inputs();
    wait_drain("clear");
  endtask

  task automatic test_starve();
    host_valid = 1'b1; host_we = 1'b1; host_addr = 11'd9; host_wdata = 4'd6;
    disp_req = 1'b1; disp_addr = 11'd9;
    for (int i = 0; i < 32; i++) begin
      disp_q.push_back('{BLANK, cyc + 1});
      @(negedge clk);
      if (i == 0) begin
        total++;
        if (host_ready !== 1'b0) begin
          bad++; $display("FAIL starve_ready: host_ready=%b required 0", host_ready);
        end
      end
      if (i == 31) begin
        total++;
        if (err_starve !== 1'b0) begin
          bad++; $display("FAIL starve_early: err_starve=%b after 31 cycles, required 0", err_starve);
        end
      end
      tick();
    end
    disp_req = 1'b0;
    @(negedge clk);
    total++;
    if ({err_starve, host_ready} !== 2'b11) begin
      bad++; $display("FAIL starve_set: err,ready=%b after 32 cycles, required 11", {err_starve, host_ready});
    end
    tick();
    host_we = 1'b0; host_wdata = 4'd0;
    host_q.push_back('{4'd6, cyc + 1});
    tick();
    idle_inputs();
    wait_drain("starve");
    total++;
    if (err_starve !== 1'b1) begin
      bad++; $display("FAIL starve_sticky: err_starve=%b after accept, required 1", err_starve);
    end
  endtask

  task automatic test_reset_midclear();
    int  wr = 0;
    logic found = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (mem_en && mem_we && mem_addr == 11'd600) begin
        found = 1'b1;
        reset = 1'b1;
        break;
      end
      tick();
    end
    total++;
    if (found !== 1'b1) begin
      bad++; $display("FAIL midclear_reach: counter 600 seen=%b, required 1", found);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({clr_busy, host_ready, err_starve} !== 3'b010) begin
      bad++; $display("FAIL midclear_state: busy,ready,err=%b required 010", {clr_busy, host_ready, err_starve});
    end
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (mem_en && mem_we) wr++;
      tick();
    end
    total++;
    if (wr !== 0 || clr_busy !== 1'b0) begin
      bad++; $display("FAIL midclear_resume: writes=%0d busy=%b after reset, required 0 and 0", wr, clr_busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_host_rw();
    test_disp_priority();
    test_back_to_back();
    test_clear();
    test_starve();
    test_reset_midclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
